// File: rtl/regfile_scan_engine_if.sv
// Register-file and stream ports of the scan engine, bundled as one interface.
// Streams are valid/ready: a beat moves on a rising edge where both are high; the sender keeps data stable while valid is high and ready is low.
interface regfile_scan_engine_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] rfReadAddr;
    logic [DATA_W-1:0] rfReadData;
    logic              rfWriteEn;
    logic [ADDR_W-1:0] rfWriteAddr;
    logic [DATA_W-1:0] rfWriteData;
    logic [DATA_W-1:0] outData;
    logic              outValid;
    logic              outReady;
    logic [DATA_W-1:0] inData;
    logic              inValid;
    logic              inReady;

    modport master (
        output rfReadAddr, rfWriteEn, rfWriteAddr, rfWriteData, outData, outValid, inReady,
        input  rfReadData, outReady, inData, inValid
    );

    modport slave (
        input  rfReadAddr, rfWriteEn, rfWriteAddr, rfWriteData, outData, outValid, inReady,
        output rfReadData, outReady, inData, inValid
    );
endinterface

// File: rtl/regfile_scan_engine.sv
// Debug/boot sequencer: dumps a wrapping register range to a stream (DUMP)
// or writes stream words into that range (LOAD) through the register-file ports.
module regfile_scan_engine #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_W-1:0]     firstAddr,
    input  logic [ADDR_W-1:0]     lastAddr,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            stateDbg,
    regfile_scan_engine_if.master bus
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DUMP_FETCH = 3'd1,
        DUMP_WAIT  = 3'd2,
        LOAD       = 3'd3,
        FINISH     = 3'd4
    } state_t;

    state_t            state;
    state_t            nextState;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W-1:0] span;
    logic              startAcc;
    logic              outHs;
    logic              inHs;
    logic              lastWord;

    // Abort masks both handshakes so the word offered in that cycle is dropped.
    assign startAcc = (state == IDLE) && start;
    assign outHs    = (state == DUMP_WAIT) && bus.outReady && !abort;
    assign inHs     = (state == LOAD) && bus.inValid && !abort;
    assign lastWord = (remaining == (ADDR_W+1)'(1));
    assign span     = lastAddr - firstAddr;

    assign busy           = (state != IDLE);
    assign done           = (state == FINISH) && !abort;
    assign bus.inReady    = (state == LOAD);
    assign bus.rfReadAddr = idx;
    assign stateDbg       = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:       if (start) nextState = mode ? LOAD : DUMP_FETCH;
            DUMP_FETCH: nextState = DUMP_WAIT;
            DUMP_WAIT:  if (outHs) nextState = lastWord ? FINISH : DUMP_FETCH;
            LOAD:       if (inHs && lastWord) nextState = FINISH;
            FINISH:     nextState = IDLE;
            default:    nextState = IDLE;
        endcase
        if (abort && (state != IDLE)) nextState = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx             <= '0;
            remaining       <= '0;
            bus.outData     <= '0;
            bus.outValid    <= 1'b0;
            bus.rfWriteEn   <= 1'b0;
            bus.rfWriteAddr <= '0;
            bus.rfWriteData <= '0;
        end else begin
            bus.rfWriteEn <= inHs;

            // remaining spans 1..2^ADDR_W, hence the extra bit.
            if (startAcc) begin
                idx       <= firstAddr;
                remaining <= {1'b0, span} + (ADDR_W+1)'(1);
            end else if (outHs || inHs) begin
                idx       <= idx + ADDR_W'(1);
                remaining <= remaining - (ADDR_W+1)'(1);
            end

            if (inHs) begin
                bus.rfWriteAddr <= idx;
                bus.rfWriteData <= bus.inData;
            end

            if ((state == DUMP_FETCH) && !abort) begin
                bus.outData  <= bus.rfReadData;
                bus.outValid <= 1'b1;
            end else if (outHs || abort) begin
                bus.outValid <= 1'b0;
            end
        end
    end
endmodule
